// File: rtl/tdm_demux8.sv
// Time-division 1-to-8 demultiplexer: steers a serial stream into lanes a..h and emits one parallel word per frame.
// Define TDM_DEMUX_SYNC_ERR_EN to add the sync_err pulse and the saturating err_count.
module tdm_demux8 #(
   parameter int SEL_W          = 3,
   parameter bit FIRST_LANE_LSB = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  din,
   input  logic                  din_valid,
   input  logic                  frame_sync,
   output logic [2**SEL_W-1:0]   dout,
   output logic                  dout_valid,
`ifdef TDM_DEMUX_SYNC_ERR_EN
   output logic                  sync_err,
   output logic [7:0]            err_count,
`endif
   output logic                  locked
);

   // state     | meaning
   // ST_HUNT   | waiting for a valid frame_sync; din ignored
   // ST_LOCKED | aligned; each valid bit fills capture[slot]
   typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

   localparam int LANES = 2**SEL_W;
   localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

   state_t              state;
   logic [SEL_W-1:0]    slot;
   logic [LANES-1:0]    capture;
   logic [LANES-1:0]    slot_word;
   logic [LANES-1:0]    lane_a_word;

   function automatic logic [SEL_W-1:0] lane_of(input logic [SEL_W-1:0] s);
      return FIRST_LANE_LSB ? s : (LAST_SLOT - s);
   endfunction

   // din placed at the bit position of the current slot, and at lane a
   always_comb begin
      slot_word   = '0;
      lane_a_word = '0;
      slot_word[lane_of(slot)]         = din;
      lane_a_word[lane_of(SEL_W'(0))]  = din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_HUNT;
         slot       <= '0;
         capture    <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         locked     <= 1'b0;
`ifdef TDM_DEMUX_SYNC_ERR_EN
         sync_err   <= 1'b0;
         err_count  <= '0;
`endif
      end else begin
         dout_valid <= 1'b0;
`ifdef TDM_DEMUX_SYNC_ERR_EN
         sync_err   <= 1'b0;
`endif
         case (state)
            ST_HUNT: begin
               if (din_valid && frame_sync) begin
                  capture <= lane_a_word;
                  slot    <= SEL_W'(1);
                  state   <= ST_LOCKED;
                  locked  <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (din_valid) begin
                  if (frame_sync && (slot != '0)) begin
                     // misaligned sync: drop the partial frame and restart at lane a
                     capture <= lane_a_word;
                     slot    <= SEL_W'(1);
`ifdef TDM_DEMUX_SYNC_ERR_EN
                     sync_err <= 1'b1;
                     if (err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
`endif
                  end else if (slot == LAST_SLOT) begin
                     dout       <= capture | slot_word;
                     dout_valid <= 1'b1;
                     capture    <= '0;
                     slot       <= '0;
                  end else begin
                     capture <= capture | slot_word;
                     slot    <= slot + SEL_W'(1);
                  end
               end
            end
            default: begin
               state  <= ST_HUNT;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Time-division 1-to-8 demultiplexer: the receive end of the 8-to-1 select-driven serialiser.
- Accepts one serial bit per valid cycle and uses an internal slot counter in place of the mux select lines s0/s1/s2.
- Steers each bit into lane a..h and presents all 8 lanes as a registered parallel word once per frame.
- Sits directly after the serial link carrying the muxed stream y.

Parameters:
- SEL_W, 3, select/slot counter width; LANES = 2**SEL_W. Only 3 is supported; other values are out of scope.
- FIRST_LANE_LSB, 1: 1 puts lane a in dout[0]; 0 puts lane a in dout[LANES-1].

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit (the muxed y stream).
- din_valid  input  1  din is sampled only when high.
- frame_sync  input  1  qualified by din_valid; marks the current bit as slot 0 (lane a).
- dout  output  LANES  parallel frame word; lanes a..h by slot order.
- dout_valid  output  1  one-cycle pulse when dout updates.
- locked  output  1  high while aligned to the frame.

Behaviour:
- Synchronous active-high reset on clk. Reset values: dout=0, dout_valid=0, locked=0, slot=0, shift/capture register=0, state=HUNT.
- Slot-to-lane mapping matches the mux select encoding: slot = {s0,s1,s2} with s0 as MSB. Slot 0 is lane a, slot 1 is lane b, …, slot 7 is lane h.
- States:
  - HUNT: ignore din until din_valid & frame_sync. That bit is captured as lane a, slot becomes 1, state goes to LOCKED, locked=1 from the next cycle.
  - LOCKED: each din_valid bit is written to capture[slot] and slot increments mod 8.
- Frame completion: a valid bit at slot 7 completes the frame.
  - On the next cycle, dout = capture with lane h included and dout_valid=1 for exactly one cycle.
  - Latency is 1 clk from the slot-7 valid bit to dout_valid.
- din_valid low: the slot holds and no capture occurs. Gaps of any length are allowed mid-frame.
- frame_sync at slot 0 while LOCKED: normal; the bit is captured as lane a.
- frame_sync at a nonzero slot while LOCKED (misalignment):
  - The partial frame is discarded; no dout_valid is produced for it.
  - The capture register is cleared, the current bit is taken as lane a, slot becomes 1, and the state stays LOCKED.
- frame_sync without din_valid: ignored.
- Between pulses, dout holds its last value.
- Capture lanes not yet written in the current frame read 0.
- Reset mid-frame: all state returns to reset values on that edge; the partial frame is lost and dout clears to 0.
- No back-pressure: the consumer must accept the dout_valid pulse.

Optional Feature:
- Macro: TDM_DEMUX_SYNC_ERR_EN.
- When defined, two ports are added:
  - sync_err (output, 1): one-cycle pulse, 1 clk after a misaligned frame_sync in LOCKED.
  - err_count (output, 8): increments on each sync_err and saturates at 255. Cleared by rst only.
- When undefined, these ports and their logic are absent and the resync behaviour is unchanged.

Test Plan:
- Reset, then din_valid with frame_sync on the first bit, bits a..h = 1,0,1,0,1,0,1,0 → dout_valid pulses 1 clk after bit h; dout=8'h55 (FIRST_LANE_LSB=1); locked=1.
- Two back-to-back frames (0xFF pattern, then all zeros) with frame_sync only on each slot 0 → dout=8'hFF then 8'h00; dout_valid pulses exactly 8 valid cycles apart.
- Same 0x55 frame with din_valid low for 3 cycles after slot 3 → identical dout=8'h55; dout_valid delayed by 3 cycles.
- frame_sync at slot 5, then a full 8-bit frame 1,1,0,0,1,1,0,0 → no pulse for the partial frame; dout=8'h33. With the macro: sync_err pulse and err_count=1.
- rst asserted at slot 4 of a frame → the next cycle shows dout=0, locked=0; bits without frame_sync are ignored until sync.
- Macro build: 300 misaligned syncs → err_count stays at 255.
